// File: rtl/stallable_pipeline_adder.sv
// Slice-pipelined adder: stage k adds bits of slice k, sum/c_out registered after STAGES edges, no input-to-output path.
// Optional stall: define SPA_STALL_EN so stop=1 freezes every register (stalled operands dropped); otherwise stop is ignored.
module stallable_pipeline_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stop,
  input  logic [WIDTH-1:0] cin_a,
  input  logic [WIDTH-1:0] cin_b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int SW = WIDTH / STAGES;

  logic adv;

`ifdef SPA_STALL_EN
  assign adv = ~stop;
`else
  logic unused_stop;
  assign unused_stop = stop;
  assign adv         = 1'b1;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int IW = WIDTH - k * SW;     // operand bits still to be consumed here
    localparam int DW = (k + 1) * SW;       // sum bits finished after this stage
    localparam int RW = WIDTH - DW;         // operand bits carried to later stages

    logic [IW-1:0] a_in, b_in;
    logic          c_prev;
    logic [SW:0]   part;
    logic [DW-1:0] sum_d, sum_q;
    logic          c_d, c_q;

    assign part = {1'b0, a_in[SW-1:0]} + {1'b0, b_in[SW-1:0]} + {{SW{1'b0}}, c_prev};
    assign c_d  = part[SW];

    if (k == 0) begin : g_first
      assign a_in   = cin_a;
      assign b_in   = cin_b;
      assign c_prev = c_in;
      assign sum_d  = part[SW-1:0];
    end else begin : g_next
      assign a_in   = g_st[k-1].g_ops.a_q;
      assign b_in   = g_st[k-1].g_ops.b_q;
      assign c_prev = g_st[k-1].c_q;
      assign sum_d  = {part[SW-1:0], g_st[k-1].sum_q};
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sum_q <= '0;
        c_q   <= 1'b0;
      end else if (adv) begin
        sum_q <= sum_d;
        c_q   <= c_d;
      end
    end

    if (RW > 0) begin : g_ops
      logic [RW-1:0] a_q, b_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_in[IW-1:SW];
          b_q <= b_in[IW-1:SW];
        end
      end
    end
  end

  assign sum   = g_st[STAGES-1].sum_q;
  assign c_out = g_st[STAGES-1].c_q;

endmodule

// File: tb/tb_stallable_pipeline_adder.sv
// Directed bench for stallable_pipeline_adder: reset, slice carries, streaming, stall (SPA_STALL_EN aware), mid-stream reset.
module tb_stallable_pipeline_adder;

  logic        clk;
  logic        rst;
  logic        stop;
  logic [31:0] cin_a;
  logic [31:0] cin_b;
  logic        c_in;
  logic [31:0] sum;
  logic        c_out;

  int n_cmp = 0;
  int n_bad = 0;

  stallable_pipeline_adder #(.WIDTH(32), .STAGES(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .stop (stop),
    .cin_a(cin_a),
    .cin_b(cin_b),
    .c_in (c_in),
    .sum  (sum),
    .c_out(c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic c);
    cin_a = a;
    cin_b = b;
    c_in  = c;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    stop = 1'b0;
    drive(32'hDEADBEEF, 32'h12345678, 1'b1);
    #1;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({c_out, sum} !== 33'h0) begin
      n_bad++;
      $display("FAIL reset_async: got %h want %h", {c_out, sum}, 33'h0);
    end
    tick();
    n_cmp++;
    if ({c_out, sum} !== 33'h0) begin
      n_bad++;
      $display("FAIL reset_held_edge: got %h want %h", {c_out, sum}, 33'h0);
    end
    rst = 1'b1;
    drive(32'd5, 32'd6, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 1) drive(32'd0, 32'd0, 1'b0);
      n_cmp++;
      if (i < 4 && {c_out, sum} !== 33'h0) begin
        n_bad++;
        $display("FAIL post_reset_zero edge %0d: got %h want %h", i, {c_out, sum}, 33'h0);
      end else if (i == 4 && {c_out, sum} !== 33'h0_0000000B) begin
        n_bad++;
        $display("FAIL post_reset_first: got %h want %h", {c_out, sum}, 33'h0_0000000B);
      end
    end
  endtask

  task automatic test_add(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic c, input logic [32:0] want);
    drive(a, b, c);
    tick();
    drive(32'd0, 32'd0, 1'b0);
    tick();
    tick();
    n_cmp++;
    if ({c_out, sum} !== 33'h0) begin
      n_bad++;
      $display("FAIL %s early: got %h want %h", name, {c_out, sum}, 33'h0);
    end
    tick();
    n_cmp++;
    if ({c_out, sum} !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, {c_out, sum}, want);
    end
  endtask

  task automatic test_back_to_back();
    logic [32:0] want [3];
    want[0] = 33'h0_00000011;
    want[1] = 33'h0_00000101;
    want[2] = 33'h0_00001001;
    drive(32'h10, 32'h1, 1'b0);
    tick();
    drive(32'h100, 32'h1, 1'b0);
    tick();
    drive(32'h1000, 32'h1, 1'b0);
    tick();
    drive(32'd0, 32'd0, 1'b0);
    n_cmp++;
    if ({c_out, sum} !== 33'h0) begin
      n_bad++;
      $display("FAIL b2b_before: got %h want %h", {c_out, sum}, 33'h0);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({c_out, sum} !== want[i]) begin
        n_bad++;
        $display("FAIL b2b_%0d: got %h want %h", i, {c_out, sum}, want[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [32:0] want [7];
`ifdef SPA_STALL_EN
    want[0] = 33'h0_33333333;
    want[1] = 33'h0_33333333;
    want[2] = 33'h0_33333333;
    want[3] = 33'h1_10000000;
    want[4] = 33'h0_00000100;
    want[5] = 33'h0_00100002;
    want[6] = 33'h0_00000000;
`else
    want[0] = 33'h0_33333333;
    want[1] = 33'h1_10000000;
    want[2] = 33'h0_00000100;
    want[3] = 33'h0_00100002;
    want[4] = 33'h0_01000002;
    want[5] = 33'h0_10000003;
    want[6] = 33'h0_00000000;
`endif
    drive(32'h11111111, 32'h22222222, 1'b0);
    tick();
    drive(32'hF0000000, 32'h20000000, 1'b0);
    tick();
    drive(32'h000000FF, 32'h00000000, 1'b1);
    tick();
    drive(32'h00100000, 32'h00000001, 1'b1);
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i == 0) begin
        stop = 1'b1;
        drive(32'h01000000, 32'h00000001, 1'b1);
      end else if (i == 1) begin
        drive(32'h10000001, 32'h00000001, 1'b1);
      end else begin
        stop = 1'b0;
        drive(32'd0, 32'd0, 1'b0);
      end
      n_cmp++;
      if ({c_out, sum} !== want[i]) begin
        n_bad++;
        $display("FAIL stall_%0d: got %h want %h", i, {c_out, sum}, want[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(32'h01010101, 32'h01010101, 1'b0);
    tick();
    drive(32'h02020202, 32'h02020202, 1'b1);
    tick();
    drive(32'h03030303, 32'h03030303, 1'b0);
    tick();
    drive(32'h04040404, 32'h04040404, 1'b1);
    tick();
    n_cmp++;
    if ({c_out, sum} !== 33'h0_02020202) begin
      n_bad++;
      $display("FAIL mid_before: got %h want %h", {c_out, sum}, 33'h0_02020202);
    end
    #2;
    stop = 1'b1;
    rst  = 1'b0;
    #1;
    n_cmp++;
    if ({c_out, sum} !== 33'h0) begin
      n_bad++;
      $display("FAIL mid_async_clear: got %h want %h", {c_out, sum}, 33'h0);
    end
    tick();
    n_cmp++;
    if ({c_out, sum} !== 33'h0) begin
      n_bad++;
      $display("FAIL mid_reset_over_stop: got %h want %h", {c_out, sum}, 33'h0);
    end
    rst  = 1'b1;
    stop = 1'b0;
    drive(32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if ({c_out, sum} !== 33'h0) begin
        n_bad++;
        $display("FAIL mid_stale_%0d: got %h want %h", i, {c_out, sum}, 33'h0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add("basic",      32'h00000001, 32'h00000001, 1'b0, 33'h0_00000002);
    test_add("cin",        32'h00001000, 32'h00000001, 1'b1, 33'h0_00001002);
    test_add("slice_cy",   32'h000000FF, 32'h00000001, 1'b0, 33'h0_00000100);
    test_add("ripple",     32'hFFFFFFFF, 32'h00000000, 1'b1, 33'h1_00000000);
    test_add("top_ovf",    32'h80000000, 32'h80000000, 1'b0, 33'h1_00000000);
    test_add("mixed",      32'h12345678, 32'h9ABCDEF0, 1'b0, 33'h0_ACF13568);
    test_add("all_ones",   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 33'h1_FFFFFFFF);
    test_add("alt_slices", 32'h00FF00FF, 32'h00010001, 1'b0, 33'h0_01000100);
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stallable_pipeline_adder.md
STALLABLE_PIPELINE_ADDER -- requirements
Module: stallable_pipeline_adder

Interface
REQ-001 Parameter WIDTH, default 32: operand and sum width in bits; SHALL be divisible by STAGES.
REQ-002 Parameter STAGES, default 4: number of pipeline stages; each stage adds one slice of WIDTH/STAGES bits (8 bits at the defaults).
REQ-003 clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low; rst=0 resets, rst=1 runs.
REQ-005 stop  input  1  stall request, active-high; while 1, the pipeline freezes.
REQ-006 cin_a  input  WIDTH  operand A.
REQ-007 cin_b  input  WIDTH  operand B.
REQ-008 c_in  input  1  carry-in, added at bit 0.
REQ-009 sum  output  WIDTH  registered result (A+B+c_in) mod 2^WIDTH.
REQ-010 c_out  output  1  registered carry-out of bit WIDTH-1.

Function
REQ-011 Stage k (k=0..STAGES-1) SHALL add slice k of A and B plus the carry registered by stage k-1 (stage 0 uses c_in).
- Stage k registers the slice-k sum bits, the slice-k carry, all previously computed lower sum bits, and the not-yet-used upper operand slices.
REQ-012 The final stage register SHALL drive sum and c_out directly, with no combinational path from any input to any output.
REQ-013 Latency: operands sampled at rising edge E SHALL appear on sum/c_out after edge E+STAGES-1 (the 4th edge at the defaults, counting E).
REQ-014 Throughput: one new operation accepted per non-stalled clock cycle; results emerge in issue order.
REQ-015 With stop=1 at a rising edge, no pipeline or output register SHALL change; sum and c_out hold.
REQ-016 Operands present during a stalled edge SHALL be discarded and never enter the pipeline.
REQ-017 When stop returns to 0, advance SHALL resume at the next edge with the in-flight data intact, extending its latency by exactly the number of stalled edges.
REQ-018 Carry SHALL propagate correctly across every slice boundary, including a full-width ripple (e.g. 0xFFFFFFFF+0+1).
REQ-019 Arithmetic is unsigned modulo 2^WIDTH; overflow is signalled only through c_out.

Reset
REQ-020 rst=0 SHALL immediately, without waiting for a clock edge, clear every pipeline register, sum and c_out to 0.
REQ-021 Reset SHALL take priority over stop; with rst=0 and stop=1, the state is cleared.
REQ-022 A reset mid-operation SHALL discard all in-flight operations.
REQ-023 After rst rises, the first valid result SHALL appear STAGES edges later; until then, outputs read 0.

Configuration
REQ-024 Macro SPA_STALL_EN defined: stop SHALL behave per REQ-015 to REQ-017.
REQ-025 Macro SPA_STALL_EN undefined: the stop port SHALL remain present but be ignored, so the pipeline advances every edge; all other behaviour is unchanged.

Verification
REQ-026 Basic add: rst=1, stop=0, A=0x00000001, B=0x00000001, c_in=0 -> sum=0x00000002, c_out=0 after 4 edges.
REQ-027 Carry-in and slice carry: A=0x00001000, B=0x00000001, c_in=1 -> sum=0x00001002; A=0x000000FF, B=0x00000001, c_in=0 -> sum=0x00000100, c_out=0.
REQ-028 Full ripple: A=0xFFFFFFFF, B=0x00000000, c_in=1 -> sum=0x00000000, c_out=1 after 4 edges.
REQ-029 Back-to-back stream:
- A=0x10,0x100,0x1000 with B=1, c_in=0 on consecutive edges -> sum=0x11,0x101,0x1001 on consecutive edges.
REQ-030 Stall:
- Issue A=0x00100000, B=1, c_in=1, then hold stop=1 for 2 edges while presenting A=0x01000000 and A=0x10000001.
- Required: outputs frozen during the stall; 0x00100002 emerges 2 edges late; neither stalled operand ever appears.
- With SPA_STALL_EN undefined: all three results appear.
REQ-031 Reset mid-stream: drive rst=0 with 3 operations in flight -> sum=0, c_out=0 immediately, and no stale result emerges after rst=1.
